// File: rtl/bulls_cows_ctrl_pkg.sv
// Shared definitions for the Bulls & Cows controller and its text-overlay decoder.
package bulls_cows_ctrl_pkg;

  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned NUM_SLOTS   = 3;
  localparam int unsigned BUF_W       = DIGIT_W * NUM_SLOTS;
  localparam int unsigned MAX_TRY_DEF = 10;

  localparam logic [DIGIT_W-1:0] EMPTY_SLOT = 4'hF;
  localparam logic [BUF_W-1:0]   EMPTY_BUF  = {NUM_SLOTS{EMPTY_SLOT}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SECRET = 3'd1,
    ST_PLAY   = 3'd2,
    ST_SCORE  = 3'd3,
    ST_WIN    = 3'd4,
    ST_LOSE   = 3'd5
  } state_t;

  // True when the three packed digits are pairwise different.
  function automatic logic all_distinct(input logic [BUF_W-1:0] v);
    return (v[11:8] != v[7:4]) && (v[11:8] != v[3:0]) && (v[7:4] != v[3:0]);
  endfunction

endpackage

// File: rtl/bc_score.sv
// Combinational scorer: A counts same-position matches, B counts cross-position matches.
module bc_score (
  input  logic [11:0] secret,
  input  logic [11:0] guess,
  output logic [1:0]  a,
  output logic [1:0]  b
);

  // Both operands hold distinct digits, so neither sum can exceed 3.
  assign a = 2'(secret[11:8] == guess[11:8]) +
             2'(secret[7:4]  == guess[7:4])  +
             2'(secret[3:0]  == guess[3:0]);

  assign b = 2'(secret[11:8] == guess[7:4])  +
             2'(secret[11:8] == guess[3:0])  +
             2'(secret[7:4]  == guess[11:8]) +
             2'(secret[7:4]  == guess[3:0])  +
             2'(secret[3:0]  == guess[11:8]) +
             2'(secret[3:0]  == guess[7:4]);

endmodule

// File: rtl/bulls_cows_ctrl.sv
// Bulls & Cows game controller: keypad entry buffer, secret/guess latching,
// one-cycle scoring and win/lose tracking. All outputs come straight from flops.
module bulls_cows_ctrl
  import bulls_cows_ctrl_pkg::*;
#(
  parameter int unsigned MAX_TRY   = MAX_TRY_DEF,
  parameter int unsigned DIGIT_MAX = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] iDigit,
  input  logic       iDigitVld,
  input  logic       iBack,
  input  logic       iEnter,
  input  logic       iNewGame,
  output logic [3:0] oNum1,
  output logic [3:0] oNum2,
  output logic [3:0] oNum3,
  output logic [1:0] oA,
  output logic [1:0] oB,
  output logic [3:0] oTry,
  output logic [2:0] oState,
  output logic       oScoreRdy,
  output logic       oErr,
  output logic       oWin,
  output logic       oLose
);

  state_t            r_state, w_state_nxt;
  logic [2:0][3:0]   r_buf, w_buf_nxt;
  logic [1:0]        r_cnt, w_cnt_nxt;
  logic              r_stale, w_stale_nxt;
  logic [BUF_W-1:0]  r_secret, w_secret_nxt;
  logic [BUF_W-1:0]  r_guess, w_guess_nxt;
  logic [1:0]        r_a, w_a_nxt, r_b, w_b_nxt;
  logic [3:0]        r_try, w_try_nxt;
  logic              r_rdy, w_rdy_nxt, r_err, w_err_nxt;
  logic              r_win, w_win_nxt, r_lose, w_lose_nxt;
  logic [1:0]        w_a, w_b;
  logic              w_entry_ok;

  bc_score u_score (
    .secret (r_secret),
    .guess  (r_guess),
    .a      (w_a),
    .b      (w_b)
  );

  assign w_entry_ok = (r_cnt == 2'd3) && all_distinct(r_buf);

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_buf    <= EMPTY_BUF;
      r_cnt    <= '0;
      r_stale  <= 1'b0;
      r_secret <= '0;
      r_guess  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_try    <= '0;
      r_rdy    <= 1'b0;
      r_err    <= 1'b0;
      r_win    <= 1'b0;
      r_lose   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_buf    <= w_buf_nxt;
      r_cnt    <= w_cnt_nxt;
      r_stale  <= w_stale_nxt;
      r_secret <= w_secret_nxt;
      r_guess  <= w_guess_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_try    <= w_try_nxt;
      r_rdy    <= w_rdy_nxt;
      r_err    <= w_err_nxt;
      r_win    <= w_win_nxt;
      r_lose   <= w_lose_nxt;
    end
  end

  // Next-state and output logic; strobe priority NewGame > Enter > Back > Digit
  always_comb begin
    w_state_nxt  = r_state;
    w_buf_nxt    = r_buf;
    w_cnt_nxt    = r_cnt;
    w_stale_nxt  = r_stale;
    w_secret_nxt = r_secret;
    w_guess_nxt  = r_guess;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_try_nxt    = r_try;
    w_rdy_nxt    = 1'b0;
    w_err_nxt    = 1'b0;

    if (iNewGame) begin
      w_state_nxt  = ST_SECRET;
      w_buf_nxt    = EMPTY_BUF;
      w_cnt_nxt    = '0;
      w_stale_nxt  = 1'b0;
      w_secret_nxt = '0;
      w_a_nxt      = '0;
      w_b_nxt      = '0;
      w_try_nxt    = '0;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_SECRET;
        ST_SECRET, ST_PLAY: begin
          if (iEnter) begin
            if (!w_entry_ok) begin
              w_err_nxt = 1'b1;
            end else if (r_state == ST_SECRET) begin
              w_secret_nxt = r_buf;
              w_buf_nxt    = EMPTY_BUF;
              w_cnt_nxt    = '0;
              w_try_nxt    = '0;
              w_state_nxt  = ST_PLAY;
            end else begin
              // The committed guess stays on display until the next digit arrives.
              w_guess_nxt = r_buf;
              w_stale_nxt = 1'b1;
              if (r_try < 4'(MAX_TRY)) w_try_nxt = r_try + 4'd1;
              w_state_nxt = ST_SCORE;
            end
          end else if (iBack) begin
            w_stale_nxt = 1'b0;
            case (r_cnt)
              2'd1:    w_buf_nxt[2] = EMPTY_SLOT;
              2'd2:    w_buf_nxt[1] = EMPTY_SLOT;
              2'd3:    w_buf_nxt[0] = EMPTY_SLOT;
              default: ;
            endcase
            if (r_cnt != 2'd0) w_cnt_nxt = r_cnt - 2'd1;
          end else if (iDigitVld) begin
            if (iDigit > 4'(DIGIT_MAX)) begin
              w_err_nxt = 1'b1;
            end else if (r_stale) begin
              w_buf_nxt   = {iDigit, EMPTY_SLOT, EMPTY_SLOT};
              w_cnt_nxt   = 2'd1;
              w_stale_nxt = 1'b0;
            end else if (r_cnt == 2'd3) begin
              w_err_nxt = 1'b1;
            end else begin
              case (r_cnt)
                2'd0:    w_buf_nxt[2] = iDigit;
                2'd1:    w_buf_nxt[1] = iDigit;
                default: w_buf_nxt[0] = iDigit;
              endcase
              w_cnt_nxt = r_cnt + 2'd1;
            end
          end
        end
        ST_SCORE: begin
          w_a_nxt   = w_a;
          w_b_nxt   = w_b;
          w_rdy_nxt = 1'b1;
          if (w_a == 2'd3)               w_state_nxt = ST_WIN;
          else if (r_try == 4'(MAX_TRY)) w_state_nxt = ST_LOSE;
          else                           w_state_nxt = ST_PLAY;
        end
        default: ;
      endcase
    end

    w_win_nxt  = (w_state_nxt == ST_WIN);
    w_lose_nxt = (w_state_nxt == ST_LOSE);
  end

  assign oNum1     = r_buf[2];
  assign oNum2     = r_buf[1];
  assign oNum3     = r_buf[0];
  assign oA        = r_a;
  assign oB        = r_b;
  assign oTry      = r_try;
  assign oState    = r_state;
  assign oScoreRdy = r_rdy;
  assign oErr      = r_err;
  assign oWin      = r_win;
  assign oLose     = r_lose;

endmodule

// File: doc/bulls_cows_ctrl.md
BULLS_COWS_CTRL -- requirements
Module: bulls_cows_ctrl

Interface
REQ-001 Parameter MAX_TRY, default 10: number of guesses allowed before a loss, range 1..15.
REQ-002 Parameter DIGIT_MAX, default 9: largest accepted decimal digit.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 iDigit  in  4  keypad digit value.
REQ-006 iDigitVld  in  1  one-cycle strobe; iDigit is valid while it is high.
REQ-007 iBack  in  1  one-cycle strobe; deletes the last entered digit.
REQ-008 iEnter  in  1  one-cycle strobe; commits the current 3-digit entry.
REQ-009 iNewGame  in  1  one-cycle strobe; abandons the game and returns to secret entry.
REQ-010 oNum1, oNum2, oNum3  out  4 each  entry buffer, most significant digit first; 4'hF marks an empty slot.
REQ-011 oA, oB  out  2 each  score of the last committed guess: A = right digit in right place, B = right digit in wrong place.
REQ-012 oTry  out  4  number of guesses committed in this game.
REQ-013 oState  out  3  encoded FSM state, for text-overlay selection.
REQ-014 oScoreRdy  out  1  one-cycle pulse when oA/oB update.
REQ-015 oErr  out  1  one-cycle pulse when an entry is rejected.
REQ-016 oWin, oLose  out  1 each  levels, high in WIN and LOSE respectively.

Function
REQ-017 States SHALL be IDLE=0, SECRET=1, PLAY=2, SCORE=3, WIN=4, LOSE=5.
REQ-018 IDLE SHALL go to SECRET on the first clock after reset deasserts.
REQ-019 Digit entry in SECRET and PLAY:
- iDigitVld with iDigit<=DIGIT_MAX and fewer than 3 digits held: append to the next empty slot.
- iDigitVld with iDigit>DIGIT_MAX, or with 3 digits already held: ignore and pulse oErr.
REQ-020 iBack SHALL clear the highest filled slot to 4'hF; iBack with an empty buffer is a no-op with no oErr.
REQ-021 iEnter SHALL be accepted only when 3 digits are held and all three are distinct. Otherwise: pulse oErr and leave the buffer unchanged.
REQ-022 Accepted iEnter in SECRET: latch the secret, clear the buffer to all 4'hF, zero oTry, go to PLAY.
REQ-023 Accepted iEnter in PLAY: latch the guess, increment oTry, go to SCORE. The buffer keeps displaying the guess until the next iDigitVld.
REQ-024 SCORE SHALL last exactly one cycle. In that cycle:
- compute A as the count of equal same-position pairs;
- compute B as the count of equal cross-position pairs (6 compares);
- register oA/oB and assert oScoreRdy.
Latency from the iEnter cycle to oScoreRdy is 2 cycles.
REQ-025 Transition out of SCORE:
- A==3: go to WIN;
- otherwise oTry==MAX_TRY: go to LOSE;
- otherwise: go to PLAY.
REQ-026 WIN and LOSE SHALL ignore iDigitVld, iBack and iEnter, and hold all outputs.
REQ-027 iNewGame in any state SHALL, on the next cycle:
- enter SECRET;
- clear the buffer and the secret;
- zero oA, oB and oTry.
REQ-028 Simultaneous strobes SHALL be resolved by the priority iNewGame > iEnter > iBack > iDigitVld. Each lower-priority strobe asserted in the same cycle is dropped silently.
REQ-029 Strobes arriving during SCORE SHALL be dropped, except iNewGame.
REQ-030 oTry SHALL saturate at MAX_TRY and never wrap.
REQ-031 While in SECRET, oNum1..3 SHALL show the entry buffer. The secret SHALL never be driven on any output.

Reset
REQ-032 Assertion of reset SHALL immediately force all of the following, including in mid-SCORE:
- state to IDLE;
- secret to 0;
- buffer to 4'hF;
- oA, oB, oTry to 0;
- oScoreRdy, oErr, oWin, oLose to 0.

Structure
REQ-033 A shared package SHALL hold the state encoding, the empty-slot constant 4'hF, and the MAX_TRY default, so the overlay logic can decode oState.
REQ-034 Scoring SHALL be a combinational sub-module, bc_score, with inputs secret[11:0] and guess[11:0] and outputs a[1:0] and b[1:0]. The FSM registers its outputs.

Verification
REQ-035 Secret 1,2,3 then guess 1,3,2 -> oScoreRdy two cycles after iEnter, oA=1, oB=2, oTry=1, state PLAY.
REQ-036 Secret 4,5,6 then guess 4,5,6 -> oA=3, oB=0, oWin=1; a later iDigitVld leaves oNum1..3 unchanged.
REQ-037 MAX_TRY=2, secret 1,2,3, guesses 7,8,9 then 9,8,7 -> after the second score oLose=1 and oTry=2.
REQ-038 Entry 5,5,1 with iEnter -> oErr pulses, state stays PLAY, oTry unchanged. A 4th digit and iDigit=12 each pulse oErr.
REQ-039 iBack after 2 digits -> oNum2=4'hF. Same-cycle iEnter+iDigitVld with 3 distinct digits held -> only the enter takes effect.
REQ-040 Reset asserted in the SCORE cycle -> outputs reach reset values before the next clock edge. iNewGame in WIN -> SECRET, oTry=0.
